// File: rtl/vend_pkg.sv
// Shared vending definitions: coin one-hot codes, coin values,
// change dispenser state encoding and a code-to-value helper.
package vend_pkg;

  // One-hot coin strobes shared with the vending controller
  localparam logic [4:0] COIN_NONE   = 5'b00000;
  localparam logic [4:0] COIN_NICKEL = 5'b00001;
  localparam logic [4:0] COIN_DIME   = 5'b00010;
  localparam logic [4:0] COIN_QUARTER = 5'b00100;
  localparam logic [4:0] COIN_HALFD  = 5'b01000;
  localparam logic [4:0] COIN_FULLD  = 5'b10000;

  // Coin values in cents
  localparam logic [6:0] VAL_NICKEL  = 7'd5;
  localparam logic [6:0] VAL_DIME    = 7'd10;
  localparam logic [6:0] VAL_QUARTER = 7'd25;
  localparam logic [6:0] VAL_HALFD   = 7'd50;
  localparam logic [6:0] VAL_FULLD   = 7'd100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } disp_state_t;

  // Value in cents of a one-hot coin code; anything else is worth nothing
  function automatic logic [6:0] coin_value(input logic [4:0] code);
    logic [6:0] v;
    case (code)
      COIN_NICKEL:  v = VAL_NICKEL;
      COIN_DIME:    v = VAL_DIME;
      COIN_QUARTER: v = VAL_QUARTER;
      COIN_HALFD:   v = VAL_HALFD;
      COIN_FULLD:   v = VAL_FULLD;
      default:      v = 7'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: returns the largest coin whose value does not
// exceed the amount still owed, so a payout can never underflow.
module change_coin_select
  import vend_pkg::*;
(
  input  logic [6:0] remaining,
  output logic [4:0] code,
  output logic [6:0] value
);

  // Largest-first comparison chain against the owed amount
  always_comb begin
    code = COIN_NONE;
    if (remaining >= VAL_FULLD) begin
      code = COIN_FULLD;
    end else if (remaining >= VAL_HALFD) begin
      code = COIN_HALFD;
    end else if (remaining >= VAL_QUARTER) begin
      code = COIN_QUARTER;
    end else if (remaining >= VAL_DIME) begin
      code = COIN_DIME;
    end else if (remaining >= VAL_NICKEL) begin
      code = COIN_NICKEL;
    end else begin
      code = COIN_NONE;
    end
    value = coin_value(code);
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change amount over valid/ready and pays it
// out one coin at a time to the hopper, greedy largest-first. A hopper that
// never acknowledges a coin trips a sticky fault that only reset clears.
// All outputs come straight from registers.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int MAX_CHANGE = 95,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_valid,
  input  logic [6:0] change_amt,
  output logic       change_ready,
  output logic [4:0] eject,
  input  logic       hopper_ack,
  output logic [6:0] remaining,
  output logic       done,
  output logic       bad_req,
  output logic       fault
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [6:0]       MAX_AMT  = 7'(MAX_CHANGE);

  disp_state_t      state_r, state_s;
  logic [6:0]       remaining_r, remaining_s;
  logic [4:0]       eject_r, eject_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
  logic             done_r, done_s;
  logic             bad_req_r, bad_req_s;
  logic             fault_r, fault_s;
  logic             ready_r;

  logic [4:0]       sel_code_s;
  logic [6:0]       sel_value_s;
  logic             amt_ok_s;

  change_coin_select u_select (
    .remaining (remaining_r),
    .code      (sel_code_s),
    .value     (sel_value_s)
  );

  // A request is payable only in whole nickels and up to the configured cap
  always_comb begin
    amt_ok_s = 1'b0;
    if (((change_amt % 7'd5) == 7'd0) && (change_amt <= MAX_AMT)) begin
      amt_ok_s = 1'b1;
    end else begin
      amt_ok_s = 1'b0;
    end
  end

  // Next-state, next-output and counter logic of the payout sequencer
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    eject_s     = COIN_NONE;
    tmo_cnt_s   = tmo_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    done_s      = 1'b0;
    bad_req_s   = 1'b0;
    fault_s     = fault_r;
    case (state_r)
      ST_IDLE: begin
        if (change_valid) begin
          if (!amt_ok_s) begin
            bad_req_s = 1'b1;
          end else if (change_amt == 7'd0) begin
            remaining_s = 7'd0;
            done_s      = 1'b1;
            state_s     = ST_DONE;
          end else begin
            remaining_s = change_amt;
            state_s     = ST_SELECT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        // sel_value_s never exceeds remaining_r, so the later subtract is safe
        eject_s   = sel_code_s;
        tmo_cnt_s = {TMO_W{1'b0}};
        state_s   = ST_EJECT;
      end
      ST_EJECT: begin
        // An ack on the last allowed cycle still wins over the timeout
        if (hopper_ack) begin
          remaining_s = remaining_r - coin_value(eject_r);
          gap_cnt_s   = {GAP_W{1'b0}};
          if (remaining_s == 7'd0) begin
            done_s  = 1'b1;
            state_s = ST_DONE;
          end else begin
            state_s = ST_GAP;
          end
        end else if (tmo_cnt_r == TMO_LAST) begin
          fault_s = 1'b1;
          state_s = ST_FAULT;
        end else begin
          eject_s   = eject_r;
          tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_SELECT;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_FAULT: begin
        fault_s = 1'b1;
        state_s = ST_FAULT;
      end
      default: begin
        remaining_s = 7'd0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset discarding any payout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= 7'd0;
      eject_r     <= COIN_NONE;
      tmo_cnt_r   <= {TMO_W{1'b0}};
      gap_cnt_r   <= {GAP_W{1'b0}};
      done_r      <= 1'b0;
      bad_req_r   <= 1'b0;
      fault_r     <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      eject_r     <= eject_s;
      tmo_cnt_r   <= tmo_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      done_r      <= done_s;
      bad_req_r   <= bad_req_s;
      fault_r     <= fault_s;
      ready_r     <= (state_s == ST_IDLE);
    end
  end

  assign change_ready = ready_r;
  assign eject        = eject_r;
  assign remaining    = remaining_r;
  assign done         = done_r;
  assign bad_req      = bad_req_r;
  assign fault        = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a timeline model (owed cents, coin start
// cycle, scheduled next-coin cycle) predicts every output each cycle;
// directed scenarios add literal expectations, then random traffic runs.
module tb_change_dispenser;

  localparam int MAXC = 95;
  localparam int TMO  = 16;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       change_valid = 1'b0;
  logic [6:0] change_amt = 7'd0;
  logic       hopper_ack = 1'b0;
  logic       change_ready;
  logic [4:0] eject;
  logic [6:0] remaining;
  logic       done;
  logic       bad_req;
  logic       fault;

  always #5 clk = ~clk;

  change_dispenser #(.MAX_CHANGE(MAXC), .TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .change_ready (change_ready),
    .eject        (eject),
    .hopper_ack   (hopper_ack),
    .remaining    (remaining),
    .done         (done),
    .bad_req      (bad_req),
    .fault        (fault)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: mode 0 idle, 1 paying, 2 done pulse, 3 fault
  int m_mode = 0;
  int m_owed = 0;
  int m_coin = 0;   // cents of the coin currently out, 0 = none
  int m_start = 0;  // edge at which the current coin became visible
  int m_next = 0;   // edge at which the next coin becomes visible
  int m_done = 0;
  int m_bad = 0;

  // hopper behaviour
  int  hold_j = 0;
  int  ack_dly = 1;   // 0 = never ack
  bit  spur_en = 1'b0;
  bit  rnd_hopper = 1'b0;

  // observation logs
  int   coins_q[$];
  int   rem_q[$];
  int   prev_ej = 0;
  int   prev_rem = 0;
  int   done_cnt = 0;
  int   bad_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int onehot_of(input int cents);
    case (cents)
      5:       return 1;
      10:      return 2;
      25:      return 4;
      50:      return 8;
      100:     return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int greedy(input int owed);
    int vals[5] = '{100, 50, 25, 10, 5};
    foreach (vals[i]) begin
      if (vals[i] <= owed) return vals[i];
    end
    return 0;
  endfunction

  // Advance the model across one rising edge using the inputs it samples
  task automatic model_edge();
    int a;
    m_done = 0;
    m_bad  = 0;
    if (rst) begin
      m_mode = 0; m_owed = 0; m_coin = 0;
      return;
    end
    a = int'(change_amt);
    case (m_mode)
      0: if (change_valid) begin
           if ((a % 5) != 0 || a > MAXC) m_bad = 1;
           else if (a == 0) begin m_owed = 0; m_done = 1; m_mode = 2; end
           else begin m_owed = a; m_mode = 1; m_next = cyc + 1; end
         end
      1: if (m_coin != 0) begin
           if (hopper_ack) begin
             m_owed -= m_coin;
             m_coin = 0;
             if (m_owed == 0) begin m_done = 1; m_mode = 2; end
             else m_next = cyc + GAP + 1;
           end else if (cyc - m_start == TMO) begin
             m_coin = 0; m_mode = 3;
           end
         end else if (cyc == m_next) begin
           m_coin = greedy(m_owed);
           m_start = cyc;
         end
      2: m_mode = 0;
      default: ;
    endcase
  endtask

  task automatic compare();
    chk("eject", eject, onehot_of(m_coin));
    chk("remaining", remaining, m_owed);
    chk("done", done, m_done);
    chk("bad_req", bad_req, m_bad);
    chk("fault", fault, (m_mode == 3) ? 1 : 0);
    chk("change_ready", change_ready, (m_mode == 0) ? 1 : 0);
    chk("eject_onehot", ($countones(eject) <= 1) ? 1 : 0, 1);
  endtask

  task automatic observe();
    if (eject != 5'd0 && prev_ej == 0) coins_q.push_back(int'(eject));
    prev_ej = int'(eject);
    if (int'(remaining) != prev_rem) rem_q.push_back(int'(remaining));
    prev_rem = int'(remaining);
    done_cnt += int'(done);
    bad_cnt += int'(bad_req);
  endtask

  task automatic drive_hopper();
    if (m_coin != 0) begin
      hold_j++;
      hopper_ack = (ack_dly != 0 && hold_j >= ack_dly);
    end else begin
      hold_j = 0;
      if (rnd_hopper) begin
        if ($urandom_range(0, 29) == 0) ack_dly = 0;
        else if ($urandom_range(0, 19) == 0) ack_dly = TMO;
        else ack_dly = $urandom_range(1, 5);
      end
      hopper_ack = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
    observe();
    drive_hopper();
  endtask

  task automatic clear_logs();
    coins_q.delete();
    rem_q.delete();
    done_cnt = 0;
    bad_cnt = 0;
  endtask

  task automatic request(input int amt);
    change_valid = 1'b1;
    change_amt = 7'(amt);
    tick();
    change_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (m_mode != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", (n < budget) ? 1 : 0, 1);
  endtask

  initial begin
    int hcnt;
    // reset
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready_lit", change_ready, 1);
    chk("rst_eject_lit", eject, 0);
    rst = 1'b0;
    tick();

    // model pins
    chk("mdl_greedy95", greedy(95), 50);
    chk("mdl_greedy40", greedy(40), 25);
    chk("mdl_greedy15", greedy(15), 10);

    // 65 cents, prompt acks
    ack_dly = 1; spur_en = 1'b0;
    clear_logs(); prev_rem = int'(remaining);
    request(65);
    run_until_idle(200);
    chk("c65_ncoins", coins_q.size(), 3);
    if (coins_q.size() == 3) begin
      chk("c65_coin0", coins_q[0], 5'b01000);
      chk("c65_coin1", coins_q[1], 5'b00010);
      chk("c65_coin2", coins_q[2], 5'b00001);
    end
    chk("c65_nrem", rem_q.size(), 4);
    if (rem_q.size() == 4) begin
      chk("c65_rem0", rem_q[0], 65);
      chk("c65_rem1", rem_q[1], 15);
      chk("c65_rem2", rem_q[2], 5);
      chk("c65_rem3", rem_q[3], 0);
    end
    chk("c65_done_cnt", done_cnt, 1);
    chk("c65_ready", change_ready, 1);

    // 95 cents
    clear_logs();
    request(95);
    run_until_idle(300);
    chk("c95_ncoins", coins_q.size(), 4);
    if (coins_q.size() == 4) begin
      chk("c95_coin0", coins_q[0], 5'b01000);
      chk("c95_coin1", coins_q[1], 5'b00100);
      chk("c95_coin2", coins_q[2], 5'b00010);
      chk("c95_coin3", coins_q[3], 5'b00010);
    end
    chk("c95_bad_cnt", bad_cnt, 0);

    // rejects and zero
    clear_logs();
    request(37);
    chk("r37_bad_lit", bad_req, 1);
    chk("r37_ready_lit", change_ready, 1);
    tick(); tick();
    request(100);
    chk("r100_bad_lit", bad_req, 1);
    tick(); tick();
    chk("rej_bad_cnt", bad_cnt, 2);
    request(0);
    chk("z0_done_lit", done, 1);
    tick(); tick();
    chk("rej_ncoins", coins_q.size(), 0);
    chk("z0_done_cnt", done_cnt, 1);

    // timeout on a stalled hopper
    clear_logs();
    ack_dly = 0;
    request(25);
    hcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (eject == 5'b00100) hcnt++;
      if (fault) break;
    end
    chk("tmo_hold_cycles", hcnt, TMO);
    chk("tmo_fault_lit", fault, 1);
    chk("tmo_eject_lit", eject, 0);
    chk("tmo_ready_lit", change_ready, 0);
    chk("tmo_rem_lit", remaining, 25);
    spur_en = 1'b1;
    change_valid = 1'b1; change_amt = 7'd10;
    repeat (6) tick();
    change_valid = 1'b0;
    chk("tmo_sticky_lit", fault, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("tmo_cleared_lit", fault, 0);
    tick();

    // ack on the last allowed cycle is a success
    clear_logs();
    spur_en = 1'b0; ack_dly = TMO;
    request(25);
    run_until_idle(100);
    chk("edge_ack_fault", fault, 0);
    chk("edge_ack_ncoins", coins_q.size(), 1);
    chk("edge_ack_done", done_cnt, 1);

    // spurious acks outside EJECT
    clear_logs();
    spur_en = 1'b1; ack_dly = 2;
    repeat (4) tick();
    request(40);
    run_until_idle(200);
    chk("spur_ncoins", coins_q.size(), 3);
    chk("spur_done", done_cnt, 1);

    // reset during the second coin of 40 cents
    clear_logs();
    spur_en = 1'b0; ack_dly = 1;
    request(40);
    for (int i = 0; i < 40; i++) begin
      if (eject == 5'b00010) break;
      tick();
    end
    chk("mid_second_coin", eject, 5'b00010);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_eject_lit", eject, 0);
    chk("mid_rem_lit", remaining, 0);
    tick(); tick();
    chk("mid_no_done", done_cnt, 0);
    clear_logs();
    request(10);
    run_until_idle(100);
    chk("mid_next_ncoins", coins_q.size(), 1);
    if (coins_q.size() == 1) chk("mid_next_dime", coins_q[0], 5'b00010);

    // random traffic
    rnd_hopper = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      change_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) change_amt = 7'($urandom_range(0, 127));
      else change_amt = 7'(5 * $urandom_range(0, 20));
      spur_en = ($urandom_range(0, 1) == 1);
      rst = (m_mode == 3 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; change_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
